// File: rtl/mastermind_pkg.sv
// Shared types and constants for the mastermind player-side logic.
package mastermind_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 3;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        FULL  = 2'd1,
        OFFER = 2'd2
    } entry_state_t;

    localparam int K_ENTER  = 0;
    localparam int K_DELETE = 1;
    localparam int K_SUBMIT = 2;
    localparam int K_CLEAR  = 3;
endpackage

// File: rtl/key_conditioner.sv
// Conditions one raw active-low pushbutton: 2-FF synchronizer, debounce, press pulse.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             armed_reg;
    logic             press_reg;
    logic [1:0]       fill_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             settle;

    assign settle = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

    // fill_reg marks when sync2_reg carries a real sample rather than its reset value;
    // the key must be seen released once before a fall counts as a press, so a key
    // held through reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            armed_reg <= 1'b0;
            press_reg <= 1'b0;
            fill_reg  <= 2'b00;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            fill_reg  <= {fill_reg[0], 1'b1};
            armed_reg <= armed_reg | (fill_reg[1] & sync2_reg);
            press_reg <= settle & ~sync2_reg & armed_reg;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;
endmodule

// File: rtl/guess_entry.sv
// Player guess entry: conditions the four keys, assembles a guess from switch digits
// and offers it to the game core over a valid/ready handshake.
module guess_entry
    import mastermind_pkg::*;
#(
    parameter int NUM_DIGITS      = mastermind_pkg::NUM_DIGITS,
    parameter int DIGIT_W         = mastermind_pkg::DIGIT_W,
    parameter int DEBOUNCE_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       KEY,
    input  logic [DIGIT_W-1:0]               sw_digit,
    output logic [NUM_DIGITS*DIGIT_W-1:0]    guess,
    output logic                             guess_valid,
    input  logic                             guess_ready,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
    output logic                             busy
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [3:0]         press;
    logic               do_clear, do_submit, do_delete, do_enter;
    entry_state_t       state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               valid_reg, valid_next;
    logic [DIGIT_W-1:0] digit_buf_reg  [NUM_DIGITS];
    logic [DIGIT_W-1:0] digit_buf_next [NUM_DIGITS];

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clk),
            .reset (reset),
            .key_n (KEY[gi]),
            .press (press[gi])
        );
    end

    // Only the highest-priority pulse of a cycle acts.
    always_comb begin
        do_clear  = press[K_CLEAR];
        do_submit = press[K_SUBMIT] & ~press[K_CLEAR];
        do_delete = press[K_DELETE] & ~press[K_SUBMIT] & ~press[K_CLEAR];
        do_enter  = press[K_ENTER]  & ~press[K_DELETE] & ~press[K_SUBMIT] & ~press[K_CLEAR];
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        valid_next     = valid_reg;
        digit_buf_next = digit_buf_reg;
        case (state_reg)
            ENTRY: begin
                if (do_clear) begin
                    count_next = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) digit_buf_next[i] = '0;
                end else if (do_delete) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - CW'(1);
                        for (int i = 0; i < NUM_DIGITS; i++)
                            if (count_reg == CW'(i + 1)) digit_buf_next[i] = '0;
                    end
                end else if (do_enter) begin
                    count_next = count_reg + CW'(1);
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (count_reg == CW'(i)) digit_buf_next[i] = sw_digit;
                    if (count_reg == CW'(NUM_DIGITS - 1)) state_next = FULL;
                end
            end
            FULL: begin
                if (do_clear) begin
                    state_next = ENTRY;
                    count_next = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) digit_buf_next[i] = '0;
                end else if (do_submit) begin
                    state_next = OFFER;
                    valid_next = 1'b1;
                end else if (do_delete) begin
                    state_next = ENTRY;
                    count_next = count_reg - CW'(1);
                    digit_buf_next[NUM_DIGITS-1] = '0;
                end
            end
            OFFER: begin
                // Keys are deliberately ignored here so the offered guess cannot change.
                if (valid_reg && guess_ready) begin
                    state_next = ENTRY;
                    valid_next = 1'b0;
                    count_next = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) digit_buf_next[i] = '0;
                end
            end
            default: state_next = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ENTRY;
            count_reg <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_buf_reg[i] <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            valid_reg     <= valid_next;
            digit_buf_reg <= digit_buf_next;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_guess
        assign guess[gi*DIGIT_W +: DIGIT_W] = digit_buf_reg[gi];
    end

    assign guess_valid = valid_reg;
    assign digit_count = count_reg;
    assign busy        = valid_reg;
endmodule
